// File: rtl/typed_chunk_pkg.sv
// Framing constants and dechunker state encoding shared by the typed chunk
// sender and receiver.
package typed_chunk_pkg;

  localparam logic [7:0] TC_ESCAPE   = 8'h00;
  localparam logic [7:0] TC_EOC      = 8'h01;
  localparam logic [7:0] TC_MIN_TYPE = 8'h02;

  typedef enum logic [1:0] {
    ST_HUNT     = 2'd0,
    ST_HUNT_ESC = 2'd1,
    ST_DATA     = 2'd2,
    ST_DATA_ESC = 2'd3
  } dechunk_state_t;

endpackage

// File: rtl/uart_rx_typed_dechunker.sv
// Strips escape/type/EOC framing from the UART RX byte stream and presents
// each completed chunk as a parallel buffer with its type and byte count.
//
// state       | meaning
// ST_HUNT     | outside a chunk, waiting for an escape byte
// ST_HUNT_ESC | escape seen outside a chunk, expecting a type byte
// ST_DATA     | inside a chunk, collecting payload
// ST_DATA_ESC | escape seen inside a chunk: literal null, EOC or restart
module uart_rx_typed_dechunker
  import typed_chunk_pkg::*;
#(
  parameter int BUFFER_BYTE_SIZE  = 3,
  parameter int BUFFER_INDEX_SIZE = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          is_rx_done,
  input  logic [7:0]                    rx_data,
  output logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
  output logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
  output logic [7:0]                    chunk_type,
  output logic                          is_chunk_ready,
  output logic                          is_chunk_error,
  output logic                          is_dechunker_idle
);

  localparam int BUF_W = BUFFER_BYTE_SIZE * 8;

  dechunk_state_t               state_q, state_d;
  logic [BUF_W-1:0]             buf_q, buf_d;
  logic [BUFFER_INDEX_SIZE-1:0] idx_q, idx_d;
  logic [7:0]                   type_q, type_d;
  logic [BUF_W-1:0]             chunk_bytes_q, chunk_bytes_d;
  logic [BUFFER_INDEX_SIZE-1:0] chunk_size_q, chunk_size_d;
  logic [7:0]                   chunk_type_q, chunk_type_d;
  logic                         ready_q, ready_d;
  logic                         error_q, error_d;

  logic                         store_en;
  logic [7:0]                   store_byte;

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    idx_d         = idx_q;
    type_d        = type_q;
    chunk_bytes_d = chunk_bytes_q;
    chunk_size_d  = chunk_size_q;
    chunk_type_d  = chunk_type_q;
    ready_d       = 1'b0;
    error_d       = 1'b0;
    store_en      = 1'b0;
    store_byte    = rx_data;

    if (is_rx_done) begin
      case (state_q)
        ST_HUNT: begin
          if (rx_data == TC_ESCAPE) state_d = ST_HUNT_ESC;
        end
        ST_HUNT_ESC: begin
          if (rx_data >= TC_MIN_TYPE) begin
            type_d  = rx_data;
            buf_d   = '0;
            idx_d   = '0;
            state_d = ST_DATA;
          end else if (rx_data == TC_EOC) begin
            state_d = ST_HUNT;
          end
        end
        ST_DATA: begin
          if (rx_data == TC_ESCAPE) begin
            state_d = ST_DATA_ESC;
          end else begin
            store_en = 1'b1;
          end
        end
        ST_DATA_ESC: begin
          if (rx_data == TC_ESCAPE) begin
            store_en   = 1'b1;
            store_byte = 8'h00;
            state_d    = ST_DATA;
          end else if (rx_data == TC_EOC) begin
            chunk_bytes_d = buf_q;
            chunk_size_d  = idx_q;
            chunk_type_d  = type_q;
            ready_d       = 1'b1;
            state_d       = ST_HUNT;
          end else begin
            // A new header inside a chunk aborts the old one and starts over
            error_d = 1'b1;
            type_d  = rx_data;
            buf_d   = '0;
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      if (store_en) begin
        if (idx_q >= BUFFER_BYTE_SIZE) begin
          error_d = 1'b1;
          buf_d   = '0;
          idx_d   = '0;
          state_d = ST_HUNT;
        end else begin
          for (int i = 0; i < BUFFER_BYTE_SIZE; i++) begin
            if (idx_q == BUFFER_INDEX_SIZE'(i)) buf_d[i*8 +: 8] = store_byte;
          end
          idx_d = idx_q + BUFFER_INDEX_SIZE'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_HUNT;
      buf_q         <= '0;
      idx_q         <= '0;
      type_q        <= '0;
      chunk_bytes_q <= '0;
      chunk_size_q  <= '0;
      chunk_type_q  <= '0;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      type_q        <= type_d;
      chunk_bytes_q <= chunk_bytes_d;
      chunk_size_q  <= chunk_size_d;
      chunk_type_q  <= chunk_type_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
    end
  end

  assign chunk_bytes       = chunk_bytes_q;
  assign chunk_byte_size   = chunk_size_q;
  assign chunk_type        = chunk_type_q;
  assign is_chunk_ready    = ready_q;
  assign is_chunk_error    = error_q;
  assign is_dechunker_idle = (state_q == ST_HUNT) || (state_q == ST_HUNT_ESC);

endmodule

// File: tb/tb_uart_rx_typed_dechunker.sv
// Bench for uart_rx_typed_dechunker: directed framing vectors plus random
// framed/noise streams checked against a queue-based chunk model.
module tb_uart_rx_typed_dechunker;

  localparam int NB = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          is_rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [NB*8-1:0] chunk_bytes;
  logic [31:0]   chunk_byte_size;
  logic [7:0]    chunk_type;
  logic          is_chunk_ready;
  logic          is_chunk_error;
  logic          is_dechunker_idle;

  uart_rx_typed_dechunker #(.BUFFER_BYTE_SIZE(NB), .BUFFER_INDEX_SIZE(32)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .is_rx_done        (is_rx_done),
    .rx_data           (rx_data),
    .chunk_bytes       (chunk_bytes),
    .chunk_byte_size   (chunk_byte_size),
    .chunk_type        (chunk_type),
    .is_chunk_ready    (is_chunk_ready),
    .is_chunk_error    (is_chunk_error),
    .is_dechunker_idle (is_dechunker_idle)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int rdy_seen = 0;
  int err_seen = 0;

  // Reference model: "inside a chunk" flag, "previous byte was an escape" flag,
  // the payload so far and the last published chunk.
  bit           m_in_chunk;
  bit           m_esc;
  logic [7:0]   m_type;
  logic [7:0]   m_payload[$];
  logic [NB*8-1:0] e_bytes;
  logic [31:0]  e_size;
  logic [7:0]   e_type;
  bit           e_rdy;
  bit           e_err;

  task automatic model_reset();
    m_in_chunk = 0;
    m_esc      = 0;
    m_type     = 8'h00;
    m_payload.delete();
    e_bytes = '0;
    e_size  = 0;
    e_type  = 8'h00;
    e_rdy   = 0;
    e_err   = 0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (m_payload.size() == NB) begin
      e_err = 1;
      m_in_chunk = 0;
      m_payload.delete();
    end else begin
      m_payload.push_back(b);
    end
  endtask

  task automatic model_step(input logic [7:0] b);
    e_rdy = 0;
    e_err = 0;
    if (!m_esc) begin
      if (b == 8'h00) m_esc = 1;
      else if (m_in_chunk) model_push(b);
    end else begin
      m_esc = 0;
      if (b == 8'h00) begin
        if (m_in_chunk) model_push(8'h00);
        else m_esc = 1;
      end else if (b == 8'h01) begin
        if (m_in_chunk) begin
          e_bytes = '0;
          for (int i = 0; i < m_payload.size(); i++) e_bytes[i*8 +: 8] = m_payload[i];
          e_size = m_payload.size();
          e_type = m_type;
          e_rdy  = 1;
        end
        m_in_chunk = 0;
      end else begin
        if (m_in_chunk) e_err = 1;
        m_in_chunk = 1;
        m_type = b;
        m_payload.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    total++;
    if (is_chunk_ready !== e_rdy) begin
      bad++;
      $display("FAIL %s ready: got %0b want %0b", tag, is_chunk_ready, e_rdy);
    end
    total++;
    if (is_chunk_error !== e_err) begin
      bad++;
      $display("FAIL %s error: got %0b want %0b", tag, is_chunk_error, e_err);
    end
    total++;
    if (is_dechunker_idle !== !m_in_chunk) begin
      bad++;
      $display("FAIL %s idle: got %0b want %0b", tag, is_dechunker_idle, !m_in_chunk);
    end
    total++;
    if (chunk_bytes !== e_bytes) begin
      bad++;
      $display("FAIL %s bytes: got %h want %h", tag, chunk_bytes, e_bytes);
    end
    total++;
    if (chunk_byte_size !== e_size) begin
      bad++;
      $display("FAIL %s size: got %0d want %0d", tag, chunk_byte_size, e_size);
    end
    total++;
    if (chunk_type !== e_type) begin
      bad++;
      $display("FAIL %s type: got %h want %h", tag, chunk_type, e_type);
    end
    if (is_chunk_ready === 1'b1) rdy_seen++;
    if (is_chunk_error === 1'b1) err_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    is_rx_done = 1'b1;
    rx_data    = b;
    @(posedge CLK);
    #1;
    model_step(b);
    compare_all($sformatf("byte_%h", b));
  endtask

  task automatic idle_cycle();
    @(negedge CLK);
    is_rx_done = 1'b0;
    rx_data    = 8'($urandom);
    @(posedge CLK);
    #1;
    e_rdy = 0;
    e_err = 0;
    compare_all("gap");
  endtask

  task automatic apply_reset(input bit with_strobe);
    @(negedge CLK);
    RST        = 1'b1;
    is_rx_done = with_strobe;
    rx_data    = 8'h00;
    @(posedge CLK);
    #1;
    model_reset();
    compare_all("reset");
    @(negedge CLK);
    RST        = 1'b0;
    is_rx_done = 1'b0;
  endtask

  task automatic expect_pulses(input string tag, input int r0, input int e0,
                               input int r_want, input int e_want);
    total++;
    if ((rdy_seen - r0) != r_want || (err_seen - e0) != e_want) begin
      bad++;
      $display("FAIL %s pulses: got ready=%0d error=%0d want ready=%0d error=%0d",
               tag, rdy_seen - r0, err_seen - e0, r_want, e_want);
    end
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    total++;
    if (chunk_bytes !== 24'h0 || chunk_byte_size !== 32'd0 || chunk_type !== 8'h00 ||
        is_dechunker_idle !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got bytes=%h size=%0d type=%h idle=%0b want 0/0/0/1",
               chunk_bytes, chunk_byte_size, chunk_type, is_dechunker_idle);
    end
    idle_cycle();
  endtask

  task automatic test_vectors();
    int r0, e0;
    r0 = rdy_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'h41); send_byte(8'h61); send_byte(8'h62);
    send_byte(8'h63); send_byte(8'h00); send_byte(8'h01);
    total++;
    if (chunk_bytes !== 24'h636261 || chunk_byte_size !== 32'd3 || chunk_type !== 8'h41) begin
      bad++;
      $display("FAIL vec_full: got %h/%0d/%h want 636261/3/41",
               chunk_bytes, chunk_byte_size, chunk_type);
    end
    expect_pulses("vec_full", r0, e0, 1, 0);
    idle_cycle();

    r0 = rdy_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h01);
    total++;
    if (chunk_bytes !== 24'h000500 || chunk_byte_size !== 32'd2 || chunk_type !== 8'h07) begin
      bad++;
      $display("FAIL vec_null: got %h/%0d/%h want 000500/2/07",
               chunk_bytes, chunk_byte_size, chunk_type);
    end
    expect_pulses("vec_null", r0, e0, 1, 0);

    r0 = rdy_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'h09); send_byte(8'h00); send_byte(8'h01);
    total++;
    if (chunk_bytes !== 24'h0 || chunk_byte_size !== 32'd0 || chunk_type !== 8'h09) begin
      bad++;
      $display("FAIL vec_empty: got %h/%0d/%h want 0/0/09",
               chunk_bytes, chunk_byte_size, chunk_type);
    end
    expect_pulses("vec_empty", r0, e0, 1, 0);

    r0 = rdy_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    total++;
    if (chunk_bytes !== 24'h0 || chunk_byte_size !== 32'd0 || chunk_type !== 8'h09) begin
      bad++;
      $display("FAIL vec_overflow_hold: got %h/%0d/%h want 0/0/09",
               chunk_bytes, chunk_byte_size, chunk_type);
    end
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h0a); send_byte(8'h5a);
    send_byte(8'h00); send_byte(8'h01);
    total++;
    if (chunk_bytes !== 24'h00005a || chunk_byte_size !== 32'd1 || chunk_type !== 8'h0a) begin
      bad++;
      $display("FAIL vec_after_overflow: got %h/%0d/%h want 00005a/1/0a",
               chunk_bytes, chunk_byte_size, chunk_type);
    end
    expect_pulses("vec_overflow", r0, e0, 1, 1);

    r0 = rdy_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h11); send_byte(8'h00);
    send_byte(8'h06); send_byte(8'h22); send_byte(8'h00); send_byte(8'h01);
    total++;
    if (chunk_bytes !== 24'h000022 || chunk_byte_size !== 32'd1 || chunk_type !== 8'h06) begin
      bad++;
      $display("FAIL vec_restart: got %h/%0d/%h want 000022/1/06",
               chunk_bytes, chunk_byte_size, chunk_type);
    end
    expect_pulses("vec_restart", r0, e0, 1, 1);

    r0 = rdy_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h11);
    apply_reset(1'b1);
    send_byte(8'h00); send_byte(8'h08); send_byte(8'haa); send_byte(8'h00);
    send_byte(8'h01);
    total++;
    if (chunk_bytes !== 24'h0000aa || chunk_byte_size !== 32'd1 || chunk_type !== 8'h08) begin
      bad++;
      $display("FAIL vec_mid_reset: got %h/%0d/%h want 0000aa/1/08",
               chunk_bytes, chunk_byte_size, chunk_type);
    end
    expect_pulses("vec_mid_reset", r0, e0, 1, 0);

    // Stray EOC and repeated escapes outside a chunk are silent
    r0 = rdy_seen; e0 = err_seen;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    expect_pulses("vec_stray", r0, e0, 0, 0);
    idle_cycle();
  endtask

  task automatic send_frame(input bit with_gaps);
    int n;
    logic [7:0] b;
    send_byte(8'h00);
    send_byte(8'($urandom_range(2, 255)));
    n = $urandom_range(0, NB + 1);
    for (int i = 0; i < n; i++) begin
      b = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      if (with_gaps && $urandom_range(0, 3) == 0) idle_cycle();
      send_byte(b);
      if (b == 8'h00) send_byte(8'h00);
    end
    if ($urandom_range(0, 9) != 0) begin
      send_byte(8'h00);
      send_byte(8'h01);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 3)));
      else send_frame(1'b0);
    end
  endtask

  task automatic test_random_gaps();
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: send_byte(8'($urandom));
        1: idle_cycle();
        default: send_frame(1'b1);
      endcase
    end
    idle_cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_typed_dechunker.md
# uart_rx_typed_dechunker

Receive-side counterpart of the typed chunk sender: consumes the byte stream from the UART RX module, strips the framing (escape + type header, null-byte escaping, end-of-chunk marker) and presents a complete chunk as a parallel buffer with its type and byte count. It sits between the UART RX byte strobe and the application logic that consumes typed chunks.

## Interface
- BUFFER_BYTE_SIZE, 3, maximum payload bytes per chunk.
- BUFFER_INDEX_SIZE, 32, width of byte counts and indices.

- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset; synchronous, active-high.
- is_rx_done  in  1  one-cycle strobe: rx_data holds a new received byte.
- rx_data  in  8  received byte, valid when is_rx_done=1.
- chunk_bytes  out  BUFFER_BYTE_SIZE*8  payload; byte i at bits [i*8+7 : i*8]; unused bytes 0.
- chunk_byte_size  out  BUFFER_INDEX_SIZE  number of payload bytes in chunk_bytes.
- chunk_type  out  8  type byte of the last completed chunk.
- is_chunk_ready  out  1  one-cycle pulse: outputs updated with a new chunk.
- is_chunk_error  out  1  one-cycle pulse: current chunk discarded.
- is_dechunker_idle  out  1  high while not inside a chunk.

## Operation
- Wire format: 0x00, type (0x02..0xFF), payload with each 0x00 sent as 0x00 0x00, then 0x00 0x01.
- Byte after a 0x00 escape: 0x00 = literal null, 0x01 = end-of-chunk, 0x02..0xFF = chunk start with that type.
- States: HUNT, HUNT_ESC, DATA, DATA_ESC. State only advances on is_rx_done=1.
- HUNT: 0x00 -> HUNT_ESC; any other byte ignored silently.
- HUNT_ESC: byte >= 0x02 -> latch working type, clear working buffer and index, -> DATA; 0x00 -> stay HUNT_ESC; 0x01 -> HUNT (stray EOC, no error).
- DATA: 0x00 -> DATA_ESC; other byte -> store at working index, index+1.
- DATA_ESC: 0x00 -> store 0x00, index+1, -> DATA; 0x01 -> commit, -> HUNT; >= 0x02 -> error pulse, restart as new chunk with that type, -> DATA.
- Commit: chunk_bytes <= working buffer, chunk_byte_size <= index, chunk_type <= working type, is_chunk_ready pulse.
- Overflow: storing a byte when index == BUFFER_BYTE_SIZE -> error pulse, discard, -> HUNT.
- Empty chunk (header immediately followed by 0x00 0x01) is valid: size 0, chunk_bytes all 0.
- Outputs hold the last committed chunk until the next commit; errors never modify them.
- is_dechunker_idle = state is HUNT or HUNT_ESC.

## Timing
- Reset: state HUNT, chunk_bytes 0, chunk_byte_size 0, chunk_type 0, is_chunk_ready 0, is_chunk_error 0, working buffer/index/type 0.
- RST has priority over a coincident is_rx_done; that byte is lost.
- Reset mid-chunk: partial chunk dropped, no error pulse.
- is_chunk_ready / is_chunk_error assert the cycle after the is_rx_done carrying the deciding byte, for exactly one cycle; new outputs valid in that same cycle.
- Back-to-back is_rx_done on consecutive cycles supported; one byte processed per cycle, no stall.
- Index arithmetic at BUFFER_INDEX_SIZE bits; comparison against BUFFER_BYTE_SIZE, no wrap.

## Structure
- Shared package typed_chunk_pkg: TC_ESCAPE=8'h00, TC_EOC=8'h01, TC_MIN_TYPE=8'h02, dechunker state encoding; sender uses the same constants.
- Single module, no sub-module; byte-lane write into the working buffer as an indexed part-select.

## Test plan
- 00 41 61 62 63 00 01, size 3 -> ready pulse, type 0x41, size 3, chunk_bytes 24'h636261.
- 00 07 00 00 05 00 01 -> type 0x07, size 2, chunk_bytes 24'h000500 (byte0=00, byte1=05).
- 00 09 00 01 -> type 0x09, size 0, chunk_bytes 0; previous chunk overwritten.
- 00 05 11 22 33 44 ... -> error pulse on 0x44, outputs unchanged, next valid chunk decodes correctly.
- 00 05 11 00 06 22 00 01 -> error pulse at 0x06, then ready with type 0x06, size 1, byte 0x22.
- RST mid-chunk after 00 05 11, then 00 08 aa 00 01 -> no error, ready with type 0x08, size 1, byte 0xAA.
